// File: rtl/network_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : network_tx_buffered
// Brief    : Credit-flow-controlled request transmitter with a small request
//            FIFO, a drain fence, and a response fan-out to N consumers.
// Revision : 1.0 - initial release
// ============================================================================
module network_tx_buffered #(
  parameter int packet_width_p    = 64,
  parameter int data_width_p      = 32,
  parameter int reg_id_width_p    = 5,
  parameter int req_fifo_els_p    = 4,
  parameter int max_out_credits_p = 16,
  parameter int num_resp_ch_p     = 3
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  // core request side
  input  logic                                     req_v_i,
  input  logic [packet_width_p-1:0]                req_packet_i,
  output logic                                     req_ready_o,
  // network side
  output logic                                     out_v_o,
  output logic [packet_width_p-1:0]                out_packet_o,
  input  logic                                     out_ready_i,
  input  logic                                     credit_return_i,
  output logic [$clog2(max_out_credits_p+1)-1:0]   out_credits_o,
  // response in
  input  logic                                     resp_v_i,
  input  logic [data_width_p-1:0]                  resp_data_i,
  input  logic [reg_id_width_p-1:0]                resp_reg_id_i,
  input  logic [$clog2(num_resp_ch_p)-1:0]         resp_ch_i,
  input  logic                                     resp_fifo_full_i,
  output logic                                     resp_yumi_o,
  // response out
  output logic [num_resp_ch_p-1:0]                 resp_v_o,
  output logic [num_resp_ch_p-1:0]                 resp_force_o,
  output logic [data_width_p-1:0]                  resp_data_o,
  output logic [reg_id_width_p-1:0]                resp_rd_o,
  input  logic [num_resp_ch_p-1:0]                 resp_yumi_i,
  // fence / status
  input  logic                                     fence_i,
  output logic                                     fence_busy_o,
  output logic                                     error_o
);

  localparam int cw  = $clog2(max_out_credits_p + 1);
  localparam int chw = $clog2(num_resp_ch_p);
  localparam int aw  = $clog2(req_fifo_els_p);
  localparam logic [cw-1:0] c_max_credits = cw'(max_out_credits_p);

  typedef enum logic [0:0] {
    FENCE_IDLE  = 1'b0,
    FENCE_DRAIN = 1'b1
  } fence_state_e;

  // FIFO storage and pointers; pointers carry an extra wrap bit so that
  // full and empty can be told apart without a separate counter.
  logic [packet_width_p-1:0] mem_q [req_fifo_els_p];
  logic [packet_width_p-1:0] mem_d [req_fifo_els_p];
  logic [aw:0]               wr_ptr_q, wr_ptr_d;
  logic [aw:0]               rd_ptr_q, rd_ptr_d;
  logic [cw-1:0]             credits_q, credits_d;
  fence_state_e              state_q, state_d;
  logic                      error_q, error_d;

  logic fifo_empty, fifo_full, enq, deq;
  logic cred_ovf, resp_ch_bad, sel_yumi;

  // Request path: FIFO status, handshakes and the outgoing head packet.
  // A full FIFO still takes a request when the head leaves in the same cycle.
  always_comb begin
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                   (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
    out_v_o      = ~fifo_empty & (credits_q != '0);
    out_packet_o = mem_q[rd_ptr_q[aw-1:0]];
    deq          = out_v_o & out_ready_i;
    req_ready_o  = reset_ni & (state_q == FENCE_IDLE) & (~fifo_full | deq);
    enq          = req_v_i & req_ready_o;
    wr_ptr_d     = enq ? (wr_ptr_q + (aw+1)'(1)) : wr_ptr_q;
    rd_ptr_d     = deq ? (rd_ptr_q + (aw+1)'(1)) : rd_ptr_q;
    mem_d        = mem_q;
    if (enq) begin
      mem_d[wr_ptr_q[aw-1:0]] = req_packet_i;
    end
  end

  // Credit counter: a send and a return in the same cycle cancel out; a
  // return with the counter already full saturates and flags an error.
  always_comb begin
    credits_d = credits_q;
    cred_ovf  = 1'b0;
    if (credit_return_i && !deq) begin
      if (credits_q == c_max_credits) begin
        cred_ovf = 1'b1;
      end else begin
        credits_d = credits_q + cw'(1);
      end
    end else if (deq && !credit_return_i) begin
      credits_d = credits_q - cw'(1);
    end
  end

  // Fence FSM: block new requests until the FIFO is empty and every
  // credit has come home.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FENCE_IDLE:  if (fence_i) state_d = FENCE_DRAIN;
      FENCE_DRAIN: if (fifo_empty && (credits_q == c_max_credits)) state_d = FENCE_IDLE;
      default:     state_d = FENCE_IDLE;
    endcase
    fence_busy_o = (state_q == FENCE_DRAIN);
  end

  // Response fan-out: steer valid/force to the addressed consumer; an
  // out-of-range channel is dropped (acknowledged) and flagged.
  always_comb begin
    resp_v_o     = '0;
    resp_force_o = '0;
    sel_yumi     = 1'b0;
    for (int i = 0; i < num_resp_ch_p; i++) begin
      if (resp_ch_i == chw'(i)) begin
        resp_v_o[i]     = resp_v_i;
        resp_force_o[i] = resp_v_i & resp_fifo_full_i;
        sel_yumi        = resp_yumi_i[i];
      end
    end
    resp_ch_bad = resp_v_i & ({1'b0, resp_ch_i} >= (chw+1)'(num_resp_ch_p));
    resp_yumi_o = resp_v_i & (sel_yumi | resp_fifo_full_i | resp_ch_bad);
    resp_data_o = resp_data_i;
    resp_rd_o   = resp_reg_id_i;
    error_d     = error_q | cred_ovf | resp_ch_bad;
  end

  assign out_credits_o = credits_q;
  assign error_o       = error_q;

  // Control state with asynchronous reset; in-flight work is discarded.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      credits_q <= c_max_credits;
      state_q   <= FENCE_IDLE;
      error_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      credits_q <= credits_d;
      state_q   <= state_d;
      error_q   <= error_d;
    end
  end

  // Packet storage needs no reset: validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_network_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_tx_buffered
// Brief    : Directed bench for network_tx_buffered; sent packets are
//            checked in order against a scoreboard queue by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_network_tx_buffered;

  localparam int PW = 64;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int NC = 3;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_v, req_ready;
  logic [PW-1:0] req_pkt;
  logic          out_v, out_ready;
  logic [PW-1:0] out_pkt;
  logic          credit_ret;
  logic [CW-1:0] credits;
  logic          resp_v, resp_full, resp_yumi_out;
  logic [DW-1:0] resp_data, resp_data_out;
  logic [RW-1:0] resp_reg, resp_rd_out;
  logic [CHW-1:0] resp_ch;
  logic [NC-1:0] resp_v_out, resp_force_out, resp_yumi_in;
  logic          fence, fence_busy, error;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int base;
  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] mon_exp;

  network_tx_buffered dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .req_v_i         (req_v),
    .req_packet_i    (req_pkt),
    .req_ready_o     (req_ready),
    .out_v_o         (out_v),
    .out_packet_o    (out_pkt),
    .out_ready_i     (out_ready),
    .credit_return_i (credit_ret),
    .out_credits_o   (credits),
    .resp_v_i        (resp_v),
    .resp_data_i     (resp_data),
    .resp_reg_id_i   (resp_reg),
    .resp_ch_i       (resp_ch),
    .resp_fifo_full_i(resp_full),
    .resp_yumi_o     (resp_yumi_out),
    .resp_v_o        (resp_v_out),
    .resp_force_o    (resp_force_out),
    .resp_data_o     (resp_data_out),
    .resp_rd_o       (resp_rd_out),
    .resp_yumi_i     (resp_yumi_in),
    .fence_i         (fence),
    .fence_busy_o    (fence_busy),
    .error_o         (error)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted network beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_v && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pkt_unexpected: got %0h, none expected", out_pkt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_pkt !== mon_exp) begin
          n_errors++;
          $display("FAIL pkt_order: got %0h expected %0h", out_pkt, mon_exp);
        end
      end
      n_pops++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send_req(input logic [PW-1:0] pkt);
    bit done = 1'b0;
    req_v   = 1'b1;
    req_pkt = pkt;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(pkt);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_accept_timeout: packet %0h never accepted", pkt);
    end
    req_v = 1'b0;
  endtask

  task automatic pulse_credits(input int n);
    for (int k = 0; k < n; k++) begin
      credit_ret = 1'b1;
      tick();
    end
    credit_ret = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_v = 1'b0; req_pkt = '0; out_ready = 1'b0; credit_ret = 1'b0;
    resp_v = 1'b0; resp_data = '0; resp_reg = '0; resp_ch = '0; resp_full = 1'b0;
    resp_yumi_in = '0; fence = 1'b0;

    // reset values
    tick(); tick();
    probe();
    chk("rst_ready", req_ready, 0);
    chk("rst_outv", out_v, 0);
    chk("rst_busy", fence_busy, 0);
    chk("rst_credits", credits, 16);
    chk("rst_error", error, 0);
    tick(); rst_n = 1'b1;
    probe();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_credits", credits, 16);
    tick();

    // one-cycle latency from empty FIFO
    out_ready = 1'b1; req_v = 1'b1; req_pkt = 64'h1111_0000_0000_0001;
    probe();
    chk("lat_outv_same", out_v, 0);
    chk("lat_ready", req_ready, 1);
    exp_q.push_back(req_pkt);
    tick(); req_v = 1'b0;
    probe();
    chk("lat_outv_next", out_v, 1);
    tick();
    probe();
    chk("lat_credits", credits, 15);
    tick(); pulse_credits(1);
    probe();
    chk("lat_credits_back", credits, 16);
    tick();

    // backpressure: fill 4, then drain in order one per cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_req(64'hB000_0000_0000_0000 + 64'(i));
    probe();
    chk("bp_ready_full", req_ready, 0);
    chk("bp_outv", out_v, 1);
    tick();
    base = n_pops; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    probe();
    chk("bp_pops", n_pops - base, 4);
    chk("bp_outv_empty", out_v, 0);
    chk("bp_credits", credits, 12);
    chk("bp_ready", req_ready, 1);
    tick(); out_ready = 1'b0; pulse_credits(4);
    probe();
    chk("bp_credits_back", credits, 16);
    tick();

    // full FIFO accepts while dequeuing in the same cycle
    for (int i = 0; i < 4; i++) send_req(64'hC000_0000_0000_0000 + 64'(i));
    out_ready = 1'b1; req_v = 1'b1; req_pkt = 64'hC000_0000_0000_0004;
    probe();
    chk("full_simul_ready", req_ready, 1);
    exp_q.push_back(req_pkt);
    tick(); req_v = 1'b0;
    repeat (4) @(posedge clk);
    probe();
    chk("full_pending", exp_q.size(), 0);
    chk("full_credits", credits, 11);
    chk("full_outv", out_v, 0);
    tick(); out_ready = 1'b0; pulse_credits(5);
    probe();
    chk("full_credits_back", credits, 16);
    tick();

    // credit exhaustion
    out_ready = 1'b1; base = n_pops;
    for (int i = 0; i < 18; i++) send_req(64'hE000_0000_0000_0000 + 64'(i));
    repeat (3) tick();
    probe();
    chk("ex_outv", out_v, 0);
    chk("ex_credits", credits, 0);
    chk("ex_pending", exp_q.size(), 2);
    chk("ex_pops", n_pops - base, 16);
    tick(); pulse_credits(1);
    repeat (3) tick();
    probe();
    chk("ex_pops_one", n_pops - base, 17);
    chk("ex_credits_one", credits, 0);
    chk("ex_outv_one", out_v, 0);
    tick(); pulse_credits(17);
    probe();
    chk("ex_credits_back", credits, 16);
    chk("ex_pending_done", exp_q.size(), 0);
    tick();

    // simultaneous send and return at 5 credits, then saturation
    for (int i = 0; i < 11; i++) send_req(64'h5000_0000_0000_0000 + 64'(i));
    repeat (2) tick();
    probe();
    chk("sim_credits_pre", credits, 5);
    tick(); out_ready = 1'b0;
    send_req(64'h5555_0000_0000_0000);
    probe();
    chk("sim_outv_pre", out_v, 1);
    tick(); out_ready = 1'b1; credit_ret = 1'b1;
    probe();
    chk("sim_outv_both", out_v, 1);
    tick(); out_ready = 1'b0; credit_ret = 1'b0;
    probe();
    chk("sim_credits", credits, 5);
    chk("sim_error", error, 0);
    tick(); pulse_credits(11);
    probe();
    chk("sat_credits_pre", credits, 16);
    tick(); pulse_credits(1);
    probe();
    chk("sat_credits", credits, 16);
    chk("sat_error", error, 1);
    tick();

    // fence with 3 outstanding
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_req(64'hF000_0000_0000_0000 + 64'(i));
    repeat (2) tick();
    probe();
    chk("fn_credits", credits, 13);
    tick(); fence = 1'b1;
    tick(); fence = 1'b0; req_v = 1'b1; req_pkt = 64'hDEAD;
    probe();
    chk("fn_busy", fence_busy, 1);
    chk("fn_ready", req_ready, 0);
    tick(); req_v = 1'b0; fence = 1'b1;
    tick(); fence = 1'b0;
    pulse_credits(2);
    probe();
    chk("fn_busy_mid", fence_busy, 1);
    chk("fn_ready_mid", req_ready, 0);
    chk("fn_credits_mid", credits, 15);
    tick(); pulse_credits(1);
    tick();
    probe();
    chk("fn_busy_done", fence_busy, 0);
    chk("fn_ready_done", req_ready, 1);
    chk("fn_credits_done", credits, 16);
    tick();

    // asynchronous reset in the middle of a drain
    out_ready = 1'b0;
    send_req(64'hA000_0000_0000_0000);
    send_req(64'hA000_0000_0000_0001);
    fence = 1'b1;
    tick(); fence = 1'b0;
    probe();
    chk("rd_busy", fence_busy, 1);
    chk("rd_outv", out_v, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rd_rst_outv", out_v, 0);
    chk("rd_rst_busy", fence_busy, 0);
    chk("rd_rst_ready", req_ready, 0);
    chk("rd_rst_credits", credits, 16);
    chk("rd_rst_error", error, 0);
    exp_q.delete();
    tick(); tick(); rst_n = 1'b1;
    probe();
    chk("rd_post_credits", credits, 16);
    chk("rd_post_outv", out_v, 0);
    chk("rd_post_busy", fence_busy, 0);
    chk("rd_post_ready", req_ready, 1);
    tick();

    // responses
    resp_v = 1'b1; resp_ch = 2'd2; resp_full = 1'b1; resp_yumi_in = 3'b000;
    resp_data = 32'hDEAD_BEEF; resp_reg = 5'd17;
    probe();
    chk("rs_v_ch2", resp_v_out, 3'b100);
    chk("rs_force_ch2", resp_force_out, 3'b100);
    chk("rs_yumi_ch2", resp_yumi_out, 1);
    chk("rs_data", resp_data_out, 32'hDEAD_BEEF);
    chk("rs_rd", resp_rd_out, 17);
    tick(); resp_ch = 2'd0; resp_full = 1'b0; resp_yumi_in = 3'b001;
    probe();
    chk("rs_v_ch0", resp_v_out, 3'b001);
    chk("rs_force_ch0", resp_force_out, 3'b000);
    chk("rs_yumi_ch0", resp_yumi_out, 1);
    tick(); resp_ch = 2'd1;
    probe();
    chk("rs_v_ch1", resp_v_out, 3'b010);
    chk("rs_yumi_ch1", resp_yumi_out, 0);
    chk("rs_error_ok", error, 0);
    tick(); resp_ch = 2'd3; resp_yumi_in = 3'b000;
    probe();
    chk("rs_v_bad", resp_v_out, 3'b000);
    chk("rs_force_bad", resp_force_out, 3'b000);
    chk("rs_yumi_bad", resp_yumi_out, 1);
    tick(); resp_v = 1'b0;
    probe();
    chk("rs_error_bad", error, 1);
    chk("rs_yumi_idle", resp_yumi_out, 0);

    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/network_tx_buffered.md
NETWORK_TX_BUFFERED -- requirements
Module: network_tx_buffered

Interface
REQ-001 SHALL have parameter packet_width_p, default 64, meaning the width in bits of an outgoing request packet, passed through unmodified.
REQ-002 SHALL have parameter data_width_p, default 32, meaning the response data width.
REQ-003 SHALL have parameter reg_id_width_p, default 5, meaning the response destination register id width.
REQ-004 SHALL have parameter req_fifo_els_p, default 4, meaning request FIFO depth; must be a power of 2 and at least 2.
REQ-005 SHALL have parameter max_out_credits_p, default 16, meaning the maximum number of outstanding requests; cw = clog2(max_out_credits_p+1).
REQ-006 SHALL have parameter num_resp_ch_p, default 3, meaning the number of response consumers (2..8); chw = clog2(num_resp_ch_p).
REQ-007 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_ni, input, 1 bit, reset that is asynchronous and active-low.
REQ-009 SHALL have port req_v_i, input, 1 bit, core request valid.
REQ-010 SHALL have port req_packet_i, input, packet_width_p bits, core request packet.
REQ-011 SHALL have port req_ready_o, output, 1 bit, request accepted when req_v_i & req_ready_o.
REQ-012 SHALL have port out_v_o, input/output pair: out_v_o output 1 bit, out_packet_o output packet_width_p bits, out_ready_i input 1 bit (network valid/ready).
REQ-013 SHALL have port credit_return_i, input, 1 bit, pulse returning one credit.
REQ-014 SHALL have port out_credits_o, output, cw bits, available credits.
REQ-015 SHALL have response-in ports: resp_v_i (in, 1), resp_data_i (in, data_width_p), resp_reg_id_i (in, reg_id_width_p), resp_ch_i (in, chw), resp_fifo_full_i (in, 1), resp_yumi_o (out, 1).
REQ-016 SHALL have response-out ports: resp_v_o (out, num_resp_ch_p), resp_force_o (out, num_resp_ch_p), resp_data_o (out, data_width_p), resp_rd_o (out, reg_id_width_p), resp_yumi_i (in, num_resp_ch_p).
REQ-017 SHALL have fence ports: fence_i (in, 1, fence request pulse), fence_busy_o (out, 1).
REQ-018 SHALL have error_o, output, 1 bit, sticky error flag.

Function
REQ-019 SHALL buffer requests in a FIFO; req_ready_o = FIFO not full & fence state IDLE.
REQ-020 SHALL drive out_v_o = FIFO not empty & credits>0, with out_packet_o = FIFO head; head is dequeued and credits are decremented on out_v_o & out_ready_i.
REQ-021 SHALL accept an enqueue and a dequeue in the same cycle when the FIFO is full; a request accepted into an empty FIFO appears on out_v_o no earlier than the next cycle (1-cycle latency).
REQ-022 SHALL leave credits unchanged on a simultaneous send and credit_return_i; otherwise apply +1 or -1.
REQ-023 SHALL saturate credits at max_out_credits_p if credit_return_i arrives while full, and set error_o.
REQ-024 SHALL implement a fence FSM with states IDLE and DRAIN: IDLE->DRAIN on fence_i; DRAIN->IDLE when FIFO empty & credits==max_out_credits_p, evaluated on the registered state.
REQ-025 SHALL assert fence_busy_o = (state==DRAIN); fence_i while in DRAIN is ignored; draining continues normally during DRAIN.
REQ-026 SHALL, for a response, set resp_v_o[resp_ch_i] = resp_v_i and all other bits to 0; resp_data_o and resp_rd_o are pass-through.
REQ-027 SHALL set resp_force_o[resp_ch_i] = resp_v_i & resp_fifo_full_i.
REQ-028 SHALL drive resp_yumi_o = resp_v_i & (resp_yumi_i[resp_ch_i] | resp_fifo_full_i).
REQ-029 SHALL, if resp_v_i arrives with resp_ch_i >= num_resp_ch_p, drive no resp_v_o, assert resp_yumi_o (drop), and set error_o.
REQ-030 SHALL clear error_o only by reset.

Reset
REQ-031 SHALL, while reset_ni=0, asynchronously force: FIFO empty, credits=max_out_credits_p, state IDLE, error_o=0.
REQ-032 SHALL keep outputs at reset values while reset_ni=0: req_ready_o=0, out_v_o=0, fence_busy_o=0, out_credits_o=max_out_credits_p.
REQ-033 SHALL abandon in-flight requests and drains when reset is asserted mid-operation; there is no recovery of lost credits.

Verification
REQ-034 SHALL cover backpressure: 4 requests with out_ready_i=0 -> req_ready_o=0 after the 4th; after ready rises, packets drain in order, one per cycle, and credits=12.
REQ-035 SHALL cover credit exhaustion: 16 sends with no returns -> out_v_o=0 with the FIFO non-empty; 1 credit_return_i -> exactly one more send.
REQ-036 SHALL cover a simultaneous send and credit_return_i at credits=5 -> credits stay 5; a return at credits=16 -> credits stay 16 and error_o=1.
REQ-037 SHALL cover fence: fence_i with 3 outstanding -> fence_busy_o=1 and req_ready_o=0 until the 3rd return; fence_busy_o=0 the next cycle.
REQ-038 SHALL cover responses: resp_ch_i=2 with resp_fifo_full_i=1 and resp_yumi_i=0 -> resp_v_o=3'b100, resp_force_o=3'b100, resp_yumi_o=1; resp_ch_i=3 -> resp_yumi_o=1, resp_v_o=0, error_o=1.
REQ-039 SHALL cover reset mid-drain: reset_ni low in DRAIN with 2 queued -> out_v_o=0, fence_busy_o=0 immediately; credits=16 after release.
